prog_fetch_arbiter: RTL

Arbiter and read sequencer for the CPU's single-port synchronous program store (8-bit address, 32-bit microcode word, data registered one clock after the address). It shares the store between the CPU instruction-fetch path and a host/debug read port. The CPU has priority; a bounded-wait counter guarantees the host forward progress. It sits between the CPU fetch stage, the debug interface and the program store. It owns the store's address input and returns read data to whichever requester was granted.

---
 rtl/prog_fetch_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/prog_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// prog_fetch_arbiter
//
// Shares the single-port synchronous program store between the CPU fetch path
// and a host/debug read port. The CPU normally wins. A bounded-wait counter
// forces a host grant after HOST_MAX_WAIT consecutive denied host cycles, so
// the host always makes progress. The block drives the store address and
// returns the registered read word to whichever port was granted the cycle
// before.
//
// Parameters
//   ADDR_W         program store address width
//   DATA_W         program word width
//   HOST_MAX_WAIT  consecutive denied host cycles before the host is forced
//                  to win (legal range 1..15)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cpu_req     CPU fetch request, level, sampled every cycle
//   cpu_addr    CPU fetch address, valid with cpu_req
//   cpu_gnt     CPU address accepted this cycle (combinational)
//   cpu_valid   cpu_data holds the word for the previous cpu_gnt cycle
//   cpu_data    CPU read data; holds the last CPU word outside valid cycles
//   host_req    host read request, same semantics as cpu_req
//   host_addr   host read address
//   host_gnt    host address accepted this cycle (combinational)
//   host_valid  host_data holds the word for the previous host_gnt cycle
//   host_data   host read data; holds the last host word outside valid cycles
//   mem_addr    program store address (combinational)
//   mem_data    program store read data, registered one clock after mem_addr
// -----------------------------------------------------------------------------
module prog_fetch_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,

  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_valid,
  output logic [DATA_W-1:0] host_data,

  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  // Who was granted in the previous cycle, i.e. whose word is on mem_data now.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  // The wait counter is 4 bits wide, which bounds HOST_MAX_WAIT to 15.
  localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

  owner_t            owner;
  logic [3:0]        host_wait;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] host_hold;
  logic              host_force;

  // ---------------------------------------------------------------------------
  // Grant and address selection
  // ---------------------------------------------------------------------------
  // A starved host beats the CPU; otherwise the CPU beats the host. With no
  // grant the previous address is replayed so the store output does not move,
  // which keeps mem_data equal to the last word read.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    host_force = 1'b0;
    cpu_gnt    = 1'b0;
    host_gnt   = 1'b0;
    mem_addr   = last_addr;

    host_force = host_req && (host_wait == MAX_WAIT);

    if (host_force) begin
      host_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (host_req) begin
      host_gnt = 1'b1;
    end

    if (cpu_gnt) begin
      mem_addr = cpu_addr;
    end else if (host_gnt) begin
      mem_addr = host_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner, wait counter and address history
  // ---------------------------------------------------------------------------
  // Grants during reset are visible on the ports but are discarded here, so a
  // read granted just before or during reset never reports valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      host_wait <= 4'd0;
      last_addr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      last_addr <= mem_addr;

      if (cpu_gnt) begin
        owner <= OWN_CPU;
      end else if (host_gnt) begin
        owner <= OWN_HOST;
      end else begin
        owner <= OWN_NONE;
      end

      // Counts consecutive denied host cycles; any host grant or a dropped
      // request restarts the count. It saturates at the forcing threshold.
      if (!host_req || host_gnt) begin
        host_wait <= 4'd0;
      end else if (host_wait != MAX_WAIT) begin
        host_wait <= host_wait + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-port data hold registers
  // ---------------------------------------------------------------------------
  // Each port captures the store word at the end of its own valid cycle, so a
  // read by one port never disturbs the data presented to the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold  <= '0;
      host_hold <= '0;
    end else begin
      if (owner == OWN_CPU) begin
        cpu_hold <= mem_data;
      end
      if (owner == OWN_HOST) begin
        host_hold <= mem_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // In the valid cycle the store word is bypassed straight through, giving a
  // one-cycle read latency and one word per clock for back-to-back grants.
  assign cpu_valid  = (owner == OWN_CPU);
  assign host_valid = (owner == OWN_HOST);
  assign cpu_data   = cpu_valid  ? mem_data : cpu_hold;
  assign host_data  = host_valid ? mem_data : host_hold;

endmodule
